// File: rtl/phys_reg_free_list_ckpt.sv
// Checkpointed circular free list of physical register tags for the rename stage.
// Define FREE_LIST_BYPASS_EN to forward an enqueued tag straight to dequeue while the list is empty.
module phys_reg_free_list_ckpt #(
    parameter int unsigned NUM_PHYS_REGS      = 64,
    parameter int unsigned NUM_ARCH_REGS      = 32,
    parameter int unsigned CHECKPOINT_COLUMNS = 4,
    localparam int unsigned PHYS_REG_WIDTH    = $clog2(NUM_PHYS_REGS),
    localparam int unsigned DEPTH             = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int unsigned IW                = $clog2(DEPTH),
    localparam int unsigned PW                = IW + 1,
    localparam int unsigned COL_WIDTH         = (CHECKPOINT_COLUMNS > 1) ? $clog2(CHECKPOINT_COLUMNS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic                      dequeue_valid,
    input  logic                      dequeue_ready,
    output logic [PHYS_REG_WIDTH-1:0] dequeue_phys_reg_tag,
    input  logic                      enqueue_valid,
    input  logic [PHYS_REG_WIDTH-1:0] enqueue_phys_reg_tag,
    input  logic                      save_checkpoint_valid,
    input  logic [COL_WIDTH-1:0]      save_checkpoint_column,
    input  logic                      restore_checkpoint_valid,
    input  logic [COL_WIDTH-1:0]      restore_checkpoint_column,
    output logic [PW-1:0]             free_count,
    output logic                      overflow_error
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("NUM_PHYS_REGS - NUM_ARCH_REGS must be a power of two >= 2");
    end

    logic [PHYS_REG_WIDTH-1:0] tags_q [DEPTH];
    logic [PW-1:0]             ckpt_q [CHECKPOINT_COLUMNS];
    logic [PW-1:0]             head_q, head_d, head_adv;
    logic [PW-1:0]             tail_q, tail_d;
    logic                      ovf_q, ovf_d;

    logic [IW-1:0] head_idx, tail_idx;
    logic          empty, full, bypass;
    logic          deq_fire, enq_fire, save_hit, restore_hit;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];

    // Status, handshakes and next-state pointers
    always_comb begin
        empty  = (head_q == tail_q);
        full   = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
`ifdef FREE_LIST_BYPASS_EN
        bypass = empty & enqueue_valid;
`else
        bypass = 1'b0;
`endif
        dequeue_valid        = ~empty | bypass;
        dequeue_phys_reg_tag = bypass ? enqueue_phys_reg_tag : tags_q[head_idx];

        deq_fire    = dequeue_valid & dequeue_ready & ~restore_checkpoint_valid;
        enq_fire    = enqueue_valid & (~full | deq_fire);
        save_hit    = save_checkpoint_valid & ~restore_checkpoint_valid
                      & (32'(save_checkpoint_column) < CHECKPOINT_COLUMNS);
        restore_hit = restore_checkpoint_valid
                      & (32'(restore_checkpoint_column) < CHECKPOINT_COLUMNS);

        head_adv = head_q + PW'(deq_fire);
        head_d   = head_adv;
        if (restore_hit) begin
            head_d = ckpt_q[restore_checkpoint_column];
        end
        tail_d = tail_q + PW'(enq_fire);
        ovf_d  = ovf_q | (enqueue_valid & ~enq_fire);
    end

    assign free_count     = tail_q - head_q;
    assign overflow_error = ovf_q;

    // Reset fills the list with the tags not mapped to architectural registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tags_q[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
            end
            for (int unsigned c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                ckpt_q[c] <= '0;
            end
            head_q <= '0;
            tail_q <= PW'(DEPTH);
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            if (enq_fire) begin
                tags_q[tail_idx] <= enqueue_phys_reg_tag;
            end
            if (save_hit) begin
                ckpt_q[save_checkpoint_column] <= head_adv;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Scoreboarded bench for phys_reg_free_list_ckpt: directed scenarios plus randomized traffic
// checked against a free-running-counter reference model.
module tb_phys_reg_free_list_ckpt;

    localparam int NPR  = 64;
    localparam int NAR  = 32;
    localparam int COLS = 4;
    localparam int D    = NPR - NAR;
    localparam int TW   = 6;
    localparam int CW   = 2;
    localparam int PW   = 6;
`ifdef FREE_LIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          dequeue_valid;
    logic          dequeue_ready;
    logic [TW-1:0] dequeue_phys_reg_tag;
    logic          enqueue_valid;
    logic [TW-1:0] enqueue_phys_reg_tag;
    logic          save_checkpoint_valid;
    logic [CW-1:0] save_checkpoint_column;
    logic          restore_checkpoint_valid;
    logic [CW-1:0] restore_checkpoint_column;
    logic [PW-1:0] free_count;
    logic          overflow_error;

    always #5 CLK = ~CLK;

    phys_reg_free_list_ckpt #(
        .NUM_PHYS_REGS      (NPR),
        .NUM_ARCH_REGS      (NAR),
        .CHECKPOINT_COLUMNS (COLS)
    ) dut (
        .CLK                       (CLK),
        .RST                       (RST),
        .dequeue_valid             (dequeue_valid),
        .dequeue_ready             (dequeue_ready),
        .dequeue_phys_reg_tag      (dequeue_phys_reg_tag),
        .enqueue_valid             (enqueue_valid),
        .enqueue_phys_reg_tag      (enqueue_phys_reg_tag),
        .save_checkpoint_valid     (save_checkpoint_valid),
        .save_checkpoint_column    (save_checkpoint_column),
        .restore_checkpoint_valid  (restore_checkpoint_valid),
        .restore_checkpoint_column (restore_checkpoint_column),
        .free_count                (free_count),
        .overflow_error            (overflow_error)
    );

    // Reference model: unbounded head/tail counters over a DEPTH-slot ring
    int m_head, m_tail;
    int m_mem [D];
    int m_saved [COLS];
    bit m_ovf;

    typedef struct {
        bit v;
        int tag;
        int cnt;
        bit ovf;
    } exp_t;
    exp_t sb_q [$];

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = NAR + i;
        for (int c = 0; c < COLS; c++) m_saved[c] = 0;
        m_head = 0;
        m_tail = D;
        m_ovf  = 1'b0;
    endfunction

    // One clock of stimulus: push the expected view of this cycle, then advance the model
    task automatic cycle(input bit rdy, input bit ev, input int etag,
                         input bit sv, input int scol, input bit rs, input int rcol);
        exp_t e;
        int   cnt;
        bit   byp, fire;
        dequeue_ready             = rdy;
        enqueue_valid             = ev;
        enqueue_phys_reg_tag      = TW'(etag);
        save_checkpoint_valid     = sv;
        save_checkpoint_column    = CW'(scol);
        restore_checkpoint_valid  = rs;
        restore_checkpoint_column = CW'(rcol);
        cnt   = m_tail - m_head;
        byp   = BYP && (cnt == 0) && ev;
        e.v   = (cnt > 0) || byp;
        e.tag = byp ? etag : m_mem[m_head % D];
        e.cnt = cnt;
        e.ovf = m_ovf;
        sb_q.push_back(e);
        @(posedge CLK);
        fire = e.v && rdy && !rs;
        if (ev) begin
            if (cnt < D || fire) begin
                m_mem[m_tail % D] = etag;
                m_tail++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (sv && !rs && scol < COLS) m_saved[scol] = m_head + int'(fire);
        if (rs) begin
            if (rcol < COLS) m_head = m_saved[rcol];
        end else begin
            m_head += int'(fire);
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic deq();
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    // Asynchronous reset between edges; outputs must snap to reset values at once
    task automatic do_reset();
        dequeue_ready            = 1'b0;
        enqueue_valid            = 1'b0;
        save_checkpoint_valid    = 1'b0;
        restore_checkpoint_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_valid", int'(dequeue_valid), 1);
        chk("rst_tag", int'(dequeue_phys_reg_tag), NAR);
        chk("rst_free_count", int'(free_count), D);
        chk("rst_overflow", int'(overflow_error), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    // Monitor: compares each presented cycle against the scoreboard head
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("deq_valid", int'(dequeue_valid), int'(e.v));
            if (e.v) chk("deq_tag", int'(dequeue_phys_reg_tag), e.tag);
            chk("free_count", int'(free_count), e.cnt);
            chk("overflow", int'(overflow_error), int'(e.ovf));
        end
    end

    initial begin
        RST                       = 1'b1;
        dequeue_ready             = 1'b0;
        enqueue_valid             = 1'b0;
        enqueue_phys_reg_tag      = '0;
        save_checkpoint_valid     = 1'b0;
        save_checkpoint_column    = '0;
        restore_checkpoint_valid  = 1'b0;
        restore_checkpoint_column = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state, three dequeues, then drain to empty and stall
        idle();
        repeat (3) deq();
        idle();
        repeat (29) deq();
        repeat (3) deq();

        // Enqueue into empty list with dispatch waiting
        cycle(1'b1, 1'b1, 12, 1'b0, 0, 1'b0, 0);
        deq();
        idle();

        // Mid-stream reset
        do_reset();

        // Checkpoint save at head 5, dequeue, restore
        repeat (5) deq();
        cycle(1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 0);
        repeat (3) deq();
        cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 2);
        idle();
        repeat (2) deq();
        // Restore with dequeue_ready and an enqueue of tag 7 together
        cycle(1'b1, 1'b1, 7, 1'b0, 0, 1'b1, 2);
        idle();
        repeat (30) deq();

        // Full list: enqueue with simultaneous dequeue is accepted, alone it overflows
        do_reset();
        cycle(1'b1, 1'b1, 9, 1'b0, 0, 1'b0, 0);
        idle();
        cycle(1'b0, 1'b1, 9, 1'b0, 0, 1'b0, 0);
        idle();
        idle();

        // Randomized traffic in segments with varying enqueue pressure
        for (int seg = 0; seg < 6; seg++) begin
            int ev_pct;
            do_reset();
            ev_pct = 20 + seg * 12;
            for (int n = 0; n < 400; n++) begin
                bit rdy, ev, sv, rs;
                int etag, scol, rcol;
                rdy  = ($urandom_range(0, 99) < 60);
                ev   = ($urandom_range(0, 99) < ev_pct);
                etag = int'($urandom_range(0, NPR - 1));
                sv   = ($urandom_range(0, 99) < 15);
                scol = int'($urandom_range(0, COLS - 1));
                rs   = ($urandom_range(0, 99) < 6);
                rcol = int'($urandom_range(0, COLS - 1));
                if (rs && (m_tail + 1 - m_saved[rcol] > D)) rs = 1'b0;
                cycle(rdy, ev, etag, sv, scol, rs, rcol);
            end
        end

        idle();
        #10;
        if (sb_q.size() != 0) chk("scoreboard_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
